cram_read_arbiter: RTL and testbench
====================================

# cram_read_arbiter

Parametrised N-master arbiter for the read-only CRAM AXI port (AR and R channels only). It merges the AR requests of `N_MASTER` read clients (core fetch, MMU, future units) onto one master port. Requests are granted round-robin, the grant index is tagged into the upper ARID bits, and each R beat is routed back by that tag. Unlike a fixed two-slot crossbar, it supports any master count and enforces a per-master outstanding-burst limit.

## Interface
Parameters:
- `N_MASTER`, 2, number of client read ports; must be ≥ 2.
- `S_ID_W`, 1, client ARID/RID width.
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, read data width.
- `MAX_OUTSTANDING`, 4, maximum accepted-but-incomplete bursts per client; must be ≥ 1.
- Derived `IDX_W` = max(1, $clog2(N_MASTER)) and `M_ID_W` = `S_ID_W` + `IDX_W`.

Ports (vectors packed per client, client 0 in the LSBs):
- `clk`  in  1  single clock; every register is on the rising edge.
- `sys_rst`  in  1  asynchronous, active-high reset.
- `s_arid`  in  N_MASTER*S_ID_W  client AR IDs.
- `s_araddr`  in  N_MASTER*ADDR_W  client AR addresses.
- `s_arlen`  in  N_MASTER*8; `s_arsize` in N_MASTER*3; `s_arburst` in N_MASTER*2: client burst attributes.
- `s_arvalid`  in  N_MASTER  and  `s_arready`  out  N_MASTER: client AR handshake.
- `s_rid`  out  N_MASTER*S_ID_W  client R IDs.
- `s_rdata`  out  N_MASTER*DATA_W; `s_rresp` out N_MASTER*2; `s_rlast` out N_MASTER: client R payload.
- `s_rvalid`  out  N_MASTER  and  `s_rready`  in  N_MASTER: client R handshake.
- `m_arid` out M_ID_W, `m_araddr` out ADDR_W, `m_arlen` out 8, `m_arsize` out 3, `m_arburst` out 2: merged AR.
- `m_arlock` out 1 = 0; `m_arcache` out 4 = 4'b0011; `m_arprot` out 3 = 0; `m_arqos` out 4 = 0: constant attributes.
- `m_arvalid`  out  1  and  `m_arready`  in  1: merged AR handshake.
- `m_rid` in M_ID_W, `m_rdata` in DATA_W, `m_rresp` in 2, `m_rlast` in 1, `m_rvalid` in 1: CRAM R channel.
- `m_rready`  out  1  CRAM R ready.
- `busy`  out  1  any outstanding count is nonzero, or `m_arvalid` = 1.
- `err_badid`  out  1  sticky flag; set when an R beat arrives with an invalid index.

## Operation
- **Eligibility:** client i is eligible when `s_arvalid[i]` = 1 and `cnt[i]` < `MAX_OUTSTANDING`.
- **Arbitration:** round-robin with pointer `rr`. Search starts at index `rr` and wraps modulo `N_MASTER`; the first eligible client wins (grant g).
- **Load condition:** `load` = (any eligible) && (!`m_arvalid` || `m_arready`).
- **On load:**
  - `s_arready[g]` = 1, combinationally, in the same cycle. All other `s_arready` bits are 0.
  - The output AR register captures `m_arid` = {g, `s_arid[g]`} plus addr, len, size and burst.
  - `m_arvalid` is set to 1.
  - `rr` ← (g+1) mod `N_MASTER`.
- **AR hold:** after `m_arvalid` & `m_arready` with no new load, `m_arvalid` clears. `m_ar*` stay stable while `m_arvalid` = 1 && !`m_arready`.
- **R routing** (combinational), with idx = `m_rid[M_ID_W-1:S_ID_W]`:
  - `s_rvalid[idx]` = `m_rvalid`; all other `s_rvalid` = 0.
  - `m_rready` = `s_rready[idx]`.
  - `s_rid` of every client = `m_rid[S_ID_W-1:0]`. `s_rdata`, `s_rresp` and `s_rlast` are broadcast to all clients.
  - Bad index (idx ≥ `N_MASTER`): `m_rready` = 1, the beat is dropped, all `s_rvalid` = 0, and `err_badid` is set until reset.
- **Outstanding counters** `cnt[i]`, width $clog2(MAX_OUTSTANDING+1):
  - +1 on `s_arvalid[i]` & `s_arready[i]`.
  - −1 on an R handshake to client i with `m_rlast` = 1.
  - Both events in the same cycle: the count is unchanged.
  - The counter never wraps, because the eligibility rule blocks increments at `MAX_OUTSTANDING`.
- **Reset (async, active-high):**
  - `m_arvalid` = 0, `rr` = 0, all `cnt` = 0, `err_badid` = 0.
  - `m_arid`, `m_araddr`, `m_arlen`, `m_arsize` and `m_arburst` are 0; `busy` = 0.
  - All `s_arready` and `s_rvalid` are 0 while reset is asserted.
  - Reset mid-burst abandons all in-flight tracking, and R beats are not replayed.

## Timing
- AR latency is 1 cycle: a client handshake in cycle t gives `m_arvalid` = 1 in cycle t+1.
- Sustained throughput is 1 AR/cycle while `m_arready` stays high.
- R path latency is 0 cycles, purely combinational. Ready passes back unregistered.
- A client's `s_arvalid` is never gated by another client's R traffic; only its own count limits it.
- `m_arready` never influences `s_arready` in the cycle where `m_arvalid` = 0.

## Test plan
1. N_MASTER=3, all clients assert `s_arvalid` continuously, `m_arready`=1 → `m_arid` index sequence 0,1,2,0,1,2, one grant per cycle, first `m_arvalid` one cycle after reset release plus the first request.
2. `m_arready` held 0 for 5 cycles with `m_araddr`=0x100 pending → `m_ar*` stable, all `s_arready`=0; `m_arready`=1 → next grant loads in that same cycle.
3. MAX_OUTSTANDING=2, client 1 issues 3 ARs with no R → third stalls (`s_arready[1]`=0); an R beat with `m_rlast`=1 and `m_rid`={1,x} → next cycle third AR accepted.
4. R burst of 4 beats with `m_rid`={2,1'b1} and `s_rready[2]` toggling → `s_rvalid` only on client 2, `s_rid`=1, `m_rready` mirrors `s_rready[2]`, `cnt[2]` decrements only on the last beat.
5. N_MASTER=3, R beat with idx=3 → `m_rready`=1, no `s_rvalid`, `err_badid`=1 and held until `sys_rst`.
6. Assert `sys_rst` mid-burst with `cnt`≠0 and `m_arvalid`=1 → outputs at reset values immediately (async), `busy`=0.

Source files
------------

// File: rtl/cram_read_arbiter_if.sv
// Bundle of client-side and CRAM-side AR/R channels for the CRAM read arbiter.
// Client vectors are packed per client, with client 0 in the LSBs.
interface cram_read_arbiter_if #(
  parameter int unsigned N_MASTER = 2,
  parameter int unsigned S_ID_W   = 1,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32
);
  localparam int unsigned IDX_W  = (N_MASTER < 2) ? 1 : $clog2(N_MASTER);
  localparam int unsigned M_ID_W = S_ID_W + IDX_W;

  logic [N_MASTER*S_ID_W-1:0] s_arid;
  logic [N_MASTER*ADDR_W-1:0] s_araddr;
  logic [N_MASTER*8-1:0]      s_arlen;
  logic [N_MASTER*3-1:0]      s_arsize;
  logic [N_MASTER*2-1:0]      s_arburst;
  logic [N_MASTER-1:0]        s_arvalid;
  logic [N_MASTER-1:0]        s_arready;

  logic [N_MASTER*S_ID_W-1:0] s_rid;
  logic [N_MASTER*DATA_W-1:0] s_rdata;
  logic [N_MASTER*2-1:0]      s_rresp;
  logic [N_MASTER-1:0]        s_rlast;
  logic [N_MASTER-1:0]        s_rvalid;
  logic [N_MASTER-1:0]        s_rready;

  logic [M_ID_W-1:0] m_arid;
  logic [ADDR_W-1:0] m_araddr;
  logic [7:0]        m_arlen;
  logic [2:0]        m_arsize;
  logic [1:0]        m_arburst;
  logic              m_arlock;
  logic [3:0]        m_arcache;
  logic [2:0]        m_arprot;
  logic [3:0]        m_arqos;
  logic              m_arvalid;
  logic              m_arready;

  logic [M_ID_W-1:0] m_rid;
  logic [DATA_W-1:0] m_rdata;
  logic [1:0]        m_rresp;
  logic              m_rlast;
  logic              m_rvalid;
  logic              m_rready;

  // Arbiter side: drives client AR ready / R payload and the merged AR.
  modport master (
    input  s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid, s_rready,
    output s_arready, s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
    output m_arid, m_araddr, m_arlen, m_arsize, m_arburst,
    output m_arlock, m_arcache, m_arprot, m_arqos, m_arvalid, m_rready,
    input  m_arready, m_rid, m_rdata, m_rresp, m_rlast, m_rvalid
  );

  // Environment side: clients plus the CRAM slave.
  modport slave (
    output s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid, s_rready,
    input  s_arready, s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
    input  m_arid, m_araddr, m_arlen, m_arsize, m_arburst,
    input  m_arlock, m_arcache, m_arprot, m_arqos, m_arvalid, m_rready,
    output m_arready, m_rid, m_rdata, m_rresp, m_rlast, m_rvalid
  );
endinterface

// File: rtl/cram_read_arbiter.sv
// Round-robin N-client arbiter for the read-only CRAM AXI port (AR and R only).
// The grant index is tagged into the upper ARID bits and used to route R beats back.
module cram_read_arbiter #(
  parameter int unsigned N_MASTER        = 2,
  parameter int unsigned S_ID_W          = 1,
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                 clk,
  input  logic                 sys_rst,
  cram_read_arbiter_if.master  bus,
  output logic                 busy,
  output logic                 err_badid
);
  localparam int unsigned IDX_W  = (N_MASTER < 2) ? 1 : $clog2(N_MASTER);
  localparam int unsigned M_ID_W = S_ID_W + IDX_W;
  localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING + 1);

  logic [CNT_W-1:0]  r_cnt [N_MASTER];
  logic [IDX_W-1:0]  r_rr;
  logic              r_arvalid;
  logic [M_ID_W-1:0] r_arid;
  logic [ADDR_W-1:0] r_araddr;
  logic [7:0]        r_arlen;
  logic [2:0]        r_arsize;
  logic [1:0]        r_arburst;
  logic              r_err;

  logic [N_MASTER-1:0] w_elig;
  logic [N_MASTER-1:0] w_arready;
  logic [N_MASTER-1:0] w_rvalid;
  logic [N_MASTER-1:0] w_rdone;
  logic                w_any;
  logic                w_load;
  logic [IDX_W-1:0]    w_grant;
  logic [IDX_W-1:0]    w_rr_next;
  logic [S_ID_W-1:0]   w_sel_id;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [7:0]          w_sel_len;
  logic [2:0]          w_sel_size;
  logic [1:0]          w_sel_burst;
  logic [IDX_W-1:0]    w_ridx;
  logic                w_bad;
  logic                w_rready_sel;
  logic                w_busy;
  int                  w_dist;
  int                  w_best;

  // Eligibility: requesting and below the per-client outstanding limit.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < int'(N_MASTER); i++) begin
      w_elig[i] = bus.s_arvalid[i] && (r_cnt[i] < CNT_W'(MAX_OUTSTANDING));
    end
  end

  // Round-robin pick: eligible client nearest to r_rr in wrap-around order.
  always_comb begin
    w_any   = 1'b0;
    w_grant = '0;
    w_best  = int'(N_MASTER);
    w_dist  = 0;
    for (int i = 0; i < int'(N_MASTER); i++) begin
      w_dist = i - int'(r_rr);
      if (w_dist < 0) w_dist = w_dist + int'(N_MASTER);
      if (w_elig[i] && (w_dist < w_best)) begin
        w_best  = w_dist;
        w_grant = IDX_W'(i);
        w_any   = 1'b1;
      end
    end
  end

  assign w_load    = w_any && (!r_arvalid || bus.m_arready);
  assign w_rr_next = (w_grant == IDX_W'(N_MASTER - 1)) ? '0 : w_grant + IDX_W'(1);

  // Grant one-hot and payload mux of the granted client.
  always_comb begin
    w_arready   = '0;
    w_sel_id    = '0;
    w_sel_addr  = '0;
    w_sel_len   = '0;
    w_sel_size  = '0;
    w_sel_burst = '0;
    for (int i = 0; i < int'(N_MASTER); i++) begin
      w_arready[i] = w_load && !sys_rst && (w_grant == IDX_W'(i));
      if (w_grant == IDX_W'(i)) begin
        w_sel_id    = bus.s_arid[i*S_ID_W +: S_ID_W];
        w_sel_addr  = bus.s_araddr[i*ADDR_W +: ADDR_W];
        w_sel_len   = bus.s_arlen[i*8 +: 8];
        w_sel_size  = bus.s_arsize[i*3 +: 3];
        w_sel_burst = bus.s_arburst[i*2 +: 2];
      end
    end
  end

  // R routing by the index tag; beats with an out-of-range index are sunk.
  assign w_ridx = bus.m_rid[M_ID_W-1:S_ID_W];
  assign w_bad  = (32'(w_ridx) >= 32'(N_MASTER));

  always_comb begin
    w_rvalid     = '0;
    w_rdone      = '0;
    w_rready_sel = 1'b0;
    for (int i = 0; i < int'(N_MASTER); i++) begin
      w_rvalid[i] = bus.m_rvalid && !w_bad && !sys_rst && (w_ridx == IDX_W'(i));
      w_rdone[i]  = w_rvalid[i] && bus.s_rready[i] && bus.m_rlast;
      if (w_ridx == IDX_W'(i)) w_rready_sel = bus.s_rready[i];
    end
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int i = 0; i < int'(N_MASTER); i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < int'(N_MASTER); i++) begin
        if (w_arready[i] && !w_rdone[i]) r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        else if (!w_arready[i] && w_rdone[i]) r_cnt[i] <= r_cnt[i] - CNT_W'(1);
      end
    end
  end

  // Output AR register; holds while the CRAM stalls.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_arvalid <= 1'b0;
      r_rr      <= '0;
      r_arid    <= '0;
      r_araddr  <= '0;
      r_arlen   <= '0;
      r_arsize  <= '0;
      r_arburst <= '0;
    end else if (w_load) begin
      r_arvalid <= 1'b1;
      r_rr      <= w_rr_next;
      r_arid    <= {w_grant, w_sel_id};
      r_araddr  <= w_sel_addr;
      r_arlen   <= w_sel_len;
      r_arsize  <= w_sel_size;
      r_arburst <= w_sel_burst;
    end else if (bus.m_arready) begin
      r_arvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) r_err <= 1'b0;
    else if (bus.m_rvalid && w_bad) r_err <= 1'b1;
  end

  always_comb begin
    w_busy = r_arvalid;
    for (int i = 0; i < int'(N_MASTER); i++) begin
      if (r_cnt[i] != '0) w_busy = 1'b1;
    end
  end

  assign bus.s_arready = w_arready;
  assign bus.s_rvalid  = w_rvalid;
  assign bus.s_rid     = {N_MASTER{bus.m_rid[S_ID_W-1:0]}};
  assign bus.s_rdata   = {N_MASTER{bus.m_rdata}};
  assign bus.s_rresp   = {N_MASTER{bus.m_rresp}};
  assign bus.s_rlast   = {N_MASTER{bus.m_rlast}};
  assign bus.m_rready  = w_bad ? 1'b1 : w_rready_sel;

  assign bus.m_arvalid = r_arvalid;
  assign bus.m_arid    = r_arid;
  assign bus.m_araddr  = r_araddr;
  assign bus.m_arlen   = r_arlen;
  assign bus.m_arsize  = r_arsize;
  assign bus.m_arburst = r_arburst;
  assign bus.m_arlock  = 1'b0;
  assign bus.m_arcache = 4'b0011;
  assign bus.m_arprot  = 3'b000;
  assign bus.m_arqos   = 4'b0000;

  assign busy      = w_busy;
  assign err_badid = r_err;
endmodule

// File: tb/tb_cram_read_arbiter.sv
// Directed bench for cram_read_arbiter: 3 clients, 1-bit client IDs, limit of 2 bursts.
module tb_cram_read_arbiter;
  localparam int unsigned N    = 3;
  localparam int unsigned SID  = 1;
  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned MAXO = 2;

  logic clk = 1'b0;
  logic sys_rst;
  logic busy;
  logic err_badid;
  int   n_assert = 0;
  int   n_fail   = 0;
  logic [2:0] exp_id [3];

  cram_read_arbiter_if #(.N_MASTER(N), .S_ID_W(SID), .ADDR_W(AW), .DATA_W(DW)) bus ();

  cram_read_arbiter #(
    .N_MASTER(N), .S_ID_W(SID), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk       (clk),
    .sys_rst   (sys_rst),
    .bus       (bus),
    .busy      (busy),
    .err_badid (err_badid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // m_arid = {index, client ARID} with s_arid = {1,0,1}
    exp_id[0] = 3'b001;
    exp_id[1] = 3'b010;
    exp_id[2] = 3'b101;

    sys_rst       = 1'b1;
    bus.s_arid    = 3'b101;
    bus.s_arvalid = '0;
    bus.s_rready  = '0;
    bus.m_arready = 1'b0;
    bus.m_rid     = '0;
    bus.m_rdata   = '0;
    bus.m_rresp   = '0;
    bus.m_rlast   = 1'b0;
    bus.m_rvalid  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.s_araddr[i*32 +: 32] = 32'h1000 + 32'(i) * 32'h100;
      bus.s_arlen[i*8 +: 8]    = 8'(i + 3);
      bus.s_arsize[i*3 +: 3]   = 3'd2;
      bus.s_arburst[i*2 +: 2]  = 2'b01;
    end

    // Reset values
    #2;
    chk("rst_arvalid", 64'(bus.m_arvalid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_arready", 64'(bus.s_arready), 64'd0);
    chk("rst_err", 64'(err_badid), 64'd0);
    chk("rst_arid", 64'(bus.m_arid), 64'd0);
    chk("rst_araddr", 64'(bus.m_araddr), 64'd0);
    chk("rst_arcache", 64'(bus.m_arcache), 64'h3);
    chk("rst_const", 64'({bus.m_arlock, bus.m_arprot, bus.m_arqos}), 64'd0);
    tick();
    tick();
    sys_rst = 1'b0;
    tick();

    // Round-robin with all clients requesting, one grant per cycle
    bus.s_arvalid = 3'b111;
    bus.m_arready = 1'b1;
    #1;
    chk("rr_first_arready", 64'(bus.s_arready), 64'b001);
    chk("rr_first_arvalid", 64'(bus.m_arvalid), 64'd0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rr_arvalid", 64'(bus.m_arvalid), 64'd1);
      chk("rr_arid", 64'(bus.m_arid), 64'(exp_id[k % 3]));
      chk("rr_arready", 64'(bus.s_arready), (k < 5) ? 64'(1 << ((k + 1) % 3)) : 64'd0);
      if (k == 0) begin
        chk("rr_araddr0", 64'(bus.m_araddr), 64'h1000);
        chk("rr_arlen0", 64'(bus.m_arlen), 64'd3);
        chk("rr_arsize0", 64'({bus.m_arsize, bus.m_arburst}), 64'b01001);
      end
    end
    bus.s_arvalid = '0;
    tick();
    chk("rr_drain_arvalid", 64'(bus.m_arvalid), 64'd0);
    chk("rr_drain_busy", 64'(busy), 64'd1);

    // 4-beat burst to client 2, ready toggling; client 2 blocked until the last beat
    bus.s_arvalid = 3'b100;
    bus.m_rid     = 3'b101;
    bus.m_rvalid  = 1'b1;
    for (int c = 0; c < 8; c++) begin
      bus.s_rready = {1'(c % 2), 2'b11};
      bus.m_rdata  = 32'hD000_0000 + 32'(c / 2);
      bus.m_rlast  = ((c / 2) == 3);
      #1;
      chk("burst_rvalid", 64'(bus.s_rvalid), 64'b100);
      chk("burst_rready", 64'(bus.m_rready), 64'(c % 2));
      chk("burst_rid", 64'(bus.s_rid), 64'b111);
      chk("burst_rdata_bcast", 64'(bus.s_rdata[31:0]), 64'(32'hD000_0000 + 32'(c / 2)));
      chk("burst_arready", 64'(bus.s_arready), 64'd0);
      tick();
    end
    bus.m_rvalid = 1'b0;
    bus.m_rlast  = 1'b0;
    bus.s_rready = '0;
    #1;
    chk("burst_cnt_dec", 64'(bus.s_arready), 64'b100);
    tick();
    chk("burst_regrant_id", 64'(bus.m_arid), 64'b101);
    bus.s_arvalid = '0;
    tick();

    // Client 1 at its limit; a last beat frees one slot on the following cycle
    bus.s_arvalid = 3'b010;
    #1;
    chk("lim_stall", 64'(bus.s_arready), 64'd0);
    bus.m_rid    = 3'b010;
    bus.m_rlast  = 1'b1;
    bus.m_rvalid = 1'b1;
    bus.s_rready = 3'b010;
    #1;
    chk("lim_rvalid", 64'(bus.s_rvalid), 64'b010);
    chk("lim_rready", 64'(bus.m_rready), 64'd1);
    chk("lim_same_cycle", 64'(bus.s_arready), 64'd0);
    tick();
    bus.m_rvalid = 1'b0;
    bus.m_rlast  = 1'b0;
    bus.s_rready = '0;
    #1;
    chk("lim_accept", 64'(bus.s_arready), 64'b010);
    tick();
    chk("lim_arvalid", 64'(bus.m_arvalid), 64'd1);
    chk("lim_arid", 64'(bus.m_arid), 64'b010);
    bus.s_arvalid = '0;

    // Simultaneous accept and completion on client 2 leaves its count unchanged
    bus.m_rid    = 3'b101;
    bus.m_rlast  = 1'b1;
    bus.m_rvalid = 1'b1;
    bus.s_rready = 3'b100;
    tick();
    bus.s_arvalid = 3'b100;
    #1;
    chk("both_arready", 64'(bus.s_arready), 64'b100);
    chk("both_rvalid", 64'(bus.s_rvalid), 64'b100);
    tick();
    bus.m_rvalid = 1'b0;
    bus.m_rlast  = 1'b0;
    bus.s_rready = '0;
    #1;
    chk("both_after", 64'(bus.s_arready), 64'b100);
    tick();
    chk("both_full", 64'(bus.s_arready), 64'd0);
    bus.s_arvalid = '0;
    tick();

    // Out-of-range index: sunk, sticky error flag
    bus.m_rid    = 3'b110;
    bus.m_rvalid = 1'b1;
    bus.s_rready = '0;
    #1;
    chk("bad_rready", 64'(bus.m_rready), 64'd1);
    chk("bad_rvalid", 64'(bus.s_rvalid), 64'd0);
    chk("bad_err_pre", 64'(err_badid), 64'd0);
    tick();
    chk("bad_err_set", 64'(err_badid), 64'd1);
    bus.m_rvalid = 1'b0;
    bus.m_rid    = '0;
    tick();
    chk("bad_err_hold", 64'(err_badid), 64'd1);

    // Free a slot on client 0, load an AR that stalls, then reset mid-flight
    bus.m_rid    = 3'b001;
    bus.m_rlast  = 1'b1;
    bus.m_rvalid = 1'b1;
    bus.s_rready = 3'b001;
    tick();
    bus.m_rvalid  = 1'b0;
    bus.m_rlast   = 1'b0;
    bus.s_rready  = '0;
    bus.m_arready = 1'b0;
    bus.s_arvalid = 3'b001;
    #1;
    chk("idle_arready_ignored", 64'(bus.s_arready), 64'b001);
    tick();
    bus.s_arvalid = '0;
    chk("pre_rst_arvalid", 64'(bus.m_arvalid), 64'd1);
    chk("pre_rst_arid", 64'(bus.m_arid), 64'b001);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    #2;
    sys_rst       = 1'b1;
    bus.m_rid     = 3'b000;
    bus.m_rvalid  = 1'b1;
    bus.s_rready  = 3'b111;
    bus.s_arvalid = 3'b111;
    #1;
    chk("arst_arvalid", 64'(bus.m_arvalid), 64'd0);
    chk("arst_arid", 64'(bus.m_arid), 64'd0);
    chk("arst_araddr", 64'(bus.m_araddr), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_err", 64'(err_badid), 64'd0);
    chk("arst_arready", 64'(bus.s_arready), 64'd0);
    chk("arst_rvalid", 64'(bus.s_rvalid), 64'd0);
    bus.m_rvalid  = 1'b0;
    bus.s_rready  = '0;
    bus.s_arvalid = '0;
    tick();
    sys_rst = 1'b0;
    tick();

    // Stalled AR stays stable; the release cycle loads the next grant immediately
    bus.s_araddr[31:0] = 32'h100;
    bus.s_arvalid      = 3'b011;
    bus.m_arready      = 1'b0;
    #1;
    chk("hold_first_arready", 64'(bus.s_arready), 64'b001);
    tick();
    chk("hold_arvalid", 64'(bus.m_arvalid), 64'd1);
    chk("hold_araddr", 64'(bus.m_araddr), 64'h100);
    chk("hold_arid", 64'(bus.m_arid), 64'b001);
    bus.s_araddr[31:0] = 32'h200;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("hold_arready", 64'(bus.s_arready), 64'd0);
      chk("hold_araddr_stable", 64'(bus.m_araddr), 64'h100);
      chk("hold_arvalid_stable", 64'(bus.m_arvalid), 64'd1);
      tick();
    end
    bus.m_arready = 1'b1;
    #1;
    chk("release_arready", 64'(bus.s_arready), 64'b010);
    tick();
    chk("release_arid", 64'(bus.m_arid), 64'b010);
    chk("release_araddr", 64'(bus.m_araddr), 64'h1100);
    bus.s_arvalid = '0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
